// File: rtl/result_forward_source.sv
// Producer end of the operand-forwarding path: S4 and write-back slots, register-file commit,
// forwarded operand and qualifiers. Optional WB-slot RN forwarding is enabled by RESULT_FWD_WB_EN.
module result_forward_source #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  input  logic [IDX_W-1:0]  res_dest,
  input  logic              res_load,
  input  logic              stall,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rn_sel,
  output logic [DATA_W-1:0] OF,
  output logic              LR0,
  output logic              LRN,
  output logic              FLRN,
  output logic              stall_req,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic              r_v4, r_vw;
  logic [DATA_W-1:0] r_d4, r_dw;
  logic [IDX_W-1:0]  r_i4, r_iw;

  logic w_cap, w_m4, w_mw, w_mw_fwd, w_rn_nz, w_r0_4, w_r0_w;

  assign w_cap = res_valid & res_load;

  // NOTE: non-blocking assignments so WB samples the pre-edge S4 contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v4 <= 1'b0;
      r_d4 <= '0;
      r_i4 <= '0;
      r_vw <= 1'b0;
      r_dw <= '0;
      r_iw <= '0;
    end else if (flush) begin
      // S4 is squashed, so nothing valid reaches WB behind the current commit.
      r_v4 <= 1'b0;
      r_vw <= 1'b0;
    end else if (stall) begin
      r_vw <= 1'b0;
    end else begin
      r_v4 <= w_cap;
      if (w_cap) begin
        r_d4 <= res_data;
        r_i4 <= res_dest;
      end
      r_vw <= r_v4;
      if (r_v4) begin
        r_dw <= r_d4;
        r_iw <= r_i4;
      end
    end
  end

  assign rf_we    = r_vw;
  assign rf_waddr = r_iw;
  assign rf_wdata = r_dw;

  assign w_rn_nz = (rn_sel != '0);
  assign w_m4    = r_v4 & (r_i4 == rn_sel);
  assign w_mw    = r_vw & (r_iw == rn_sel);
  assign w_r0_4  = r_v4 & (r_i4 == '0);
  assign w_r0_w  = r_vw & (r_iw == '0);

`ifdef RESULT_FWD_WB_EN
  assign w_mw_fwd = w_mw;
`else
  assign w_mw_fwd = 1'b0;
`endif

  // RN matches take priority over the R0 path; with rn_sel==0 both paths agree.
  always_comb begin
    OF = '0;
    if (w_rn_nz & w_m4)
      OF = r_d4;
    else if (w_rn_nz & w_mw)
      OF = w_mw_fwd ? r_dw : '0;
    else if (w_r0_4)
      OF = r_d4;
    else if (w_r0_w)
      OF = r_dw;
  end

  assign LR0       = w_r0_4 | w_r0_w;
  assign LRN       = w_rn_nz & (w_m4 | w_mw);
  assign FLRN      = LRN & (w_m4 | w_mw_fwd);
  assign stall_req = LRN & ~FLRN;

endmodule
